// File: rtl/vlc_pkg.sv
// Shared constants and types for the BER checker: m-sequence x^7+x^6+1
// taps, FSM state encoding and the default counter width.
package vlc_pkg;

    localparam int MSQ_LEN   = 7;
    localparam int MSQ_TAP_A = 6;
    localparam int MSQ_TAP_B = 5;
    localparam int CNT_W_DEF = 32;

    typedef enum logic [1:0] {
        ST_FILL = 2'd0,
        ST_SYNC = 2'd1,
        ST_LOCK = 2'd2
    } ber_state_t;

    function automatic logic msq_tap(input logic [MSQ_LEN-1:0] h);
        return h[MSQ_TAP_A] ^ h[MSQ_TAP_B];
    endfunction

endpackage

// File: rtl/msq_predict.sv
// 7-bit m-sequence history with tap XOR; the shifted-in bit is either the
// received bit or the locally predicted one.
module msq_predict
    import vlc_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic shift,
    input  logic flush,
    input  logic use_pred,
    input  logic data_in,
    output logic pred
);

    logic [MSQ_LEN-1:0] hist;

    assign pred = msq_tap(hist);

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            hist <= '0;
        end else if (shift) begin
            hist <= {hist[MSQ_LEN-2:0], (use_pred ? pred : data_in)};
        end
    end

endmodule

// File: rtl/bit_ber_check.sv
// Bit error rate checker against the x^7+x^6+1 m-sequence.
// Optional macro BER_FIRST_ERR_EN builds the first-error index capture.
module bit_ber_check
    import vlc_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int SYNC_LEN    = 16,
    parameter int LOSS_THRESH = 8,
    parameter int WINDOW_LEN  = 100000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             data_in,
    input  logic             data_valid,
    input  logic             clear,
    output logic             locked,
    output logic [CNT_W-1:0] bit_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic             ber_done,
    output logic [CNT_W-1:0] first_err_idx
);

    // state   | meaning
    // ST_FILL | loading 7 received bits into the history
    // ST_SYNC | counting consecutive matches towards lock
    // ST_LOCK | free-running prediction, counting bits and errors

    localparam int MW = $clog2(SYNC_LEN + 1);

    ber_state_t       state;
    logic [2:0]       fill_cnt;
    logic [MW-1:0]    match_cnt;
    logic [5:0]       blk_cnt;
    logic [6:0]       blk_err;
    logic [6:0]       blk_err_nxt;
    logic [CNT_W-1:0] bit_inc;
    logic             pred;
    logic             mismatch;
    logic             cnt_en;
    logic             loss;

    assign mismatch    = data_in ^ pred;
    assign cnt_en      = (state == ST_LOCK) && data_valid;
    assign blk_err_nxt = blk_err + {6'b0, mismatch};
    assign loss        = cnt_en && mismatch && (int'(blk_err_nxt) >= LOSS_THRESH);
    assign bit_inc     = (&bit_cnt) ? bit_cnt : bit_cnt + 1'b1;

    msq_predict u_predict (
        .clk      (clk),
        .reset    (reset),
        .shift    (data_valid),
        .flush    (loss),
        .use_pred (state == ST_LOCK),
        .data_in  (data_in),
        .pred     (pred)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_FILL;
            fill_cnt  <= '0;
            match_cnt <= '0;
            blk_cnt   <= '0;
            blk_err   <= '0;
            locked    <= 1'b0;
            bit_cnt   <= '0;
            err_cnt   <= '0;
            ber_done  <= 1'b0;
        end else begin
            ber_done <= 1'b0;
            if (data_valid) begin
                case (state)
                    ST_FILL: begin
                        if (fill_cnt == 3'(MSQ_LEN - 1)) begin
                            fill_cnt <= '0;
                            state    <= ST_SYNC;
                        end else begin
                            fill_cnt <= fill_cnt + 3'd1;
                        end
                    end
                    ST_SYNC: begin
                        if (mismatch) begin
                            match_cnt <= '0;
                        end else if (match_cnt == MW'(SYNC_LEN - 1)) begin
                            match_cnt <= '0;
                            state     <= ST_LOCK;
                            locked    <= 1'b1;
                        end else begin
                            match_cnt <= match_cnt + 1'b1;
                        end
                    end
                    ST_LOCK: begin
                        blk_cnt <= blk_cnt + 6'd1;
                        if (loss) begin
                            state   <= ST_FILL;
                            locked  <= 1'b0;
                            blk_cnt <= '0;
                            blk_err <= '0;
                        end else if (blk_cnt == 6'd63) begin
                            blk_err <= '0;
                        end else begin
                            blk_err <= blk_err_nxt;
                        end
                    end
                    default: begin
                        state  <= ST_FILL;
                        locked <= 1'b0;
                    end
                endcase
            end
            // clear only touches the counters; lock tracking above still advances
            if (clear) begin
                bit_cnt <= '0;
                err_cnt <= '0;
            end else if (cnt_en) begin
                bit_cnt  <= bit_inc;
                ber_done <= (bit_inc != bit_cnt) && (64'(bit_inc) == 64'(WINDOW_LEN));
                if (mismatch && !(&err_cnt)) begin
                    err_cnt <= err_cnt + 1'b1;
                end
            end
        end
    end

`ifdef BER_FIRST_ERR_EN
    logic err_seen;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            first_err_idx <= '0;
            err_seen      <= 1'b0;
        end else if (cnt_en && mismatch && !err_seen) begin
            first_err_idx <= bit_cnt;
            err_seen      <= 1'b1;
        end
    end
`else
    assign first_err_idx = '0;
`endif

endmodule

// File: tb/tb_bit_ber_check.sv
// Scoreboard bench for bit_ber_check: a main instance plus a 4-bit
// saturation instance share one m-sequence stimulus stream.
module tb_bit_ber_check;

    localparam int SIG_LOCKED = 0;
    localparam int SIG_BIT    = 1;
    localparam int SIG_ERR    = 2;
    localparam int SIG_FIRST  = 3;
    localparam int SIG_DONE   = 4;
    localparam int SIG_SLOCK  = 5;
    localparam int SIG_SBIT   = 6;
    localparam int SIG_SERR   = 7;
    localparam int SIG_SFIRST = 8;
    localparam int SIG_SDONE  = 9;

`ifdef BER_FIRST_ERR_EN
    localparam bit FE_ON = 1'b1;
`else
    localparam bit FE_ON = 1'b0;
`endif

    typedef struct {
        logic [95:0] tag;
        int          due;
        int          sig;
        longint      val;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset, data_in, data_valid, clear;
    logic        locked, ber_done;
    logic [31:0] bit_cnt, err_cnt, first_err_idx;
    logic        s_locked, s_ber_done;
    logic [3:0]  s_bit_cnt, s_err_cnt, s_first_err_idx;

    logic [6:0]  gen;
    exp_t        sb[$];
    int          edge_n = 0;
    int          checks = 0;
    int          errors = 0;
    int          done_pulses = 0;

    always #5 clk = ~clk;
    always @(posedge clk) edge_n <= edge_n + 1;

    bit_ber_check #(.CNT_W(32), .SYNC_LEN(16), .LOSS_THRESH(8), .WINDOW_LEN(60)) u_dut (
        .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid),
        .clear(clear), .locked(locked), .bit_cnt(bit_cnt), .err_cnt(err_cnt),
        .ber_done(ber_done), .first_err_idx(first_err_idx)
    );

    bit_ber_check #(.CNT_W(4), .SYNC_LEN(16), .LOSS_THRESH(64), .WINDOW_LEN(10)) u_sat (
        .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid),
        .clear(clear), .locked(s_locked), .bit_cnt(s_bit_cnt), .err_cnt(s_err_cnt),
        .ber_done(s_ber_done), .first_err_idx(s_first_err_idx)
    );

    task automatic check_val(input logic [95:0] tag, input longint got, input longint want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s observed %0d expected %0d", tag, got, want);
        end
    endtask

    function automatic longint observe(input int sig);
        case (sig)
            SIG_LOCKED: return longint'(locked);
            SIG_BIT:    return longint'(bit_cnt);
            SIG_ERR:    return longint'(err_cnt);
            SIG_FIRST:  return longint'(first_err_idx);
            SIG_DONE:   return longint'(ber_done);
            SIG_SLOCK:  return longint'(s_locked);
            SIG_SBIT:   return longint'(s_bit_cnt);
            SIG_SERR:   return longint'(s_err_cnt);
            SIG_SFIRST: return longint'(s_first_err_idx);
            default:    return longint'(s_ber_done);
        endcase
    endfunction

    // expectation applies to outputs after the next clock edge
    task automatic expect_val(input logic [95:0] tag, input int sig, input longint val);
        sb.push_back('{tag, edge_n + 1, sig, val});
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (ber_done) done_pulses++;
            while (sb.size() > 0 && sb[0].due == edge_n) begin
                exp_t e;
                e = sb.pop_front();
                check_val(e.tag, observe(e.sig), e.val);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic drive(input logic d, input logic v, input logic c);
        data_in    = d;
        data_valid = v;
        clear      = c;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic inv, input logic c);
        logic nb;
        nb  = gen[6] ^ gen[5];
        gen = {gen[5:0], nb};
        drive(nb ^ inv, 1'b1, c);
    endtask

    task automatic send_n(input int n);
        for (int k = 0; k < n; k++) send(1'b0, 1'b0);
    endtask

    task automatic idle();
        logic r;
        r = 1'($urandom_range(0, 1));
        drive(r, 1'b0, 1'b0);
    endtask

    task automatic expect_zero(input logic [95:0] tag);
        expect_val(tag, SIG_LOCKED, 0);
        expect_val(tag, SIG_BIT, 0);
        expect_val(tag, SIG_ERR, 0);
        expect_val(tag, SIG_FIRST, 0);
        expect_val(tag, SIG_DONE, 0);
    endtask

    initial begin
        gen   = 7'h01;
        reset = 1'b1;
        expect_zero("rst");
        drive(1'b1, 1'b1, 1'b1);
        drive(1'b0, 1'b1, 1'b0);
        reset = 1'b0;

        // clean sequence: lock after 23 bits, then 1000 counted bits
        send_n(21);
        expect_val("a_pre_lock", SIG_LOCKED, 0);
        send(1'b0, 1'b0);
        expect_val("a_lock", SIG_LOCKED, 1);
        expect_val("a_lock_bit", SIG_BIT, 0);
        send(1'b0, 1'b0);
        send_n(58);
        expect_val("a_done59", SIG_DONE, 0);
        send(1'b0, 1'b0);
        expect_val("a_done60", SIG_DONE, 1);
        expect_val("a_bit60", SIG_BIT, 60);
        send(1'b0, 1'b0);
        expect_val("a_done61", SIG_DONE, 0);
        send(1'b0, 1'b0);
        send_n(938);
        expect_val("a_bit1000", SIG_BIT, 1000);
        expect_val("a_err0", SIG_ERR, 0);
        expect_val("a_locked", SIG_LOCKED, 1);
        send(1'b0, 1'b0);

        // clear with valid bit, then a single inverted bit
        expect_val("b_clr_bit", SIG_BIT, 0);
        expect_val("b_clr_err", SIG_ERR, 0);
        send(1'b0, 1'b1);
        send_n(49);
        expect_val("b_err1", SIG_ERR, 1);
        expect_val("b_bit50", SIG_BIT, 50);
        expect_val("b_first", SIG_FIRST, FE_ON ? 49 : 0);
        expect_val("b_locked", SIG_LOCKED, 1);
        send(1'b1, 1'b0);
        send_n(9);
        expect_val("b_rearm", SIG_DONE, 1);
        send(1'b0, 1'b0);
        send_n(19);
        expect_val("b_err_once", SIG_ERR, 1);
        expect_val("b_still_lk", SIG_LOCKED, 1);
        expect_val("b_bit80", SIG_BIT, 80);
        send(1'b0, 1'b0);

        // eight errors inside one block drop lock
        send(1'b0, 1'b1);
        send_n(16);
        repeat (6) send(1'b1, 1'b0);
        expect_val("c_err7_lk", SIG_LOCKED, 1);
        expect_val("c_err7", SIG_ERR, 7);
        send(1'b1, 1'b0);
        expect_val("c_loss", SIG_LOCKED, 0);
        expect_val("c_err8", SIG_ERR, 8);
        expect_val("c_bit24", SIG_BIT, 24);
        expect_val("c_first", SIG_FIRST, FE_ON ? 16 : 0);
        send(1'b1, 1'b0);
        send_n(21);
        expect_val("c_pre_relk", SIG_LOCKED, 0);
        expect_val("c_keep_err", SIG_ERR, 8);
        send(1'b0, 1'b0);
        expect_val("c_relock", SIG_LOCKED, 1);
        expect_val("c_keep_bit", SIG_BIT, 24);
        send(1'b0, 1'b0);

        // data_valid toggling every cycle
        reset = 1'b1;
        drive(1'b0, 1'b1, 1'b0);
        reset = 1'b0;
        for (int i = 1; i <= 46; i++) begin
            if (i == 45) expect_val("d_pre_lock", SIG_LOCKED, 0);
            if (i == 46) expect_val("d_lock", SIG_LOCKED, 1);
            if (i % 2 == 0) send(1'b0, 1'b0);
            else idle();
        end
        for (int i = 1; i <= 1000; i++) begin
            if (i == 61) begin
                expect_val("d_done_end", SIG_DONE, 0);
                expect_val("d_hold_bit", SIG_BIT, 60);
            end
            idle();
            if (i == 60) expect_val("d_done60", SIG_DONE, 1);
            if (i == 1000) begin
                expect_val("d_bit1000", SIG_BIT, 1000);
                expect_val("d_err0", SIG_ERR, 0);
                expect_val("d_locked", SIG_LOCKED, 1);
            end
            send(1'b0, 1'b0);
        end

        // reset mid-lock with clear and valid, then a single ber_done
        reset = 1'b1;
        expect_zero("e_rst");
        drive(1'b1, 1'b1, 1'b1);
        reset = 1'b0;
        done_pulses = 0;
        send_n(21);
        expect_val("e_pre_lock", SIG_LOCKED, 0);
        send(1'b0, 1'b0);
        expect_val("e_lock", SIG_LOCKED, 1);
        send(1'b0, 1'b0);
        expect_val("e_clr_bit", SIG_BIT, 0);
        expect_val("e_clr_lk", SIG_LOCKED, 1);
        send(1'b0, 1'b1);
        send_n(59);
        expect_val("e_done60", SIG_DONE, 1);
        send(1'b0, 1'b0);
        send_n(140);
        check_val("e_done_cnt", done_pulses, 1);

        // saturation on the 4-bit instance
        reset = 1'b1;
        drive(1'b0, 1'b1, 1'b0);
        reset = 1'b0;
        send_n(22);
        expect_val("f_lock", SIG_SLOCK, 1);
        expect_val("f_bit0", SIG_SBIT, 0);
        send(1'b0, 1'b0);
        for (int i = 1; i <= 20; i++) begin
            if (i == 10) expect_val("f_done10", SIG_SDONE, 1);
            if (i == 11) expect_val("f_done11", SIG_SDONE, 0);
            if (i == 15) expect_val("f_err15", SIG_SERR, 15);
            if (i == 20) begin
                expect_val("f_err_sat", SIG_SERR, 15);
                expect_val("f_bit_sat", SIG_SBIT, 15);
                expect_val("f_locked", SIG_SLOCK, 1);
                expect_val("f_first", SIG_SFIRST, 0);
            end
            send(1'b1, 1'b0);
        end

        @(negedge clk);
        #1;
        check_val("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bit_ber_check.md
BIT_BER_CHECK -- requirements
Module: bit_ber_check

Interface
REQ-001 Parameter CNT_W, default 32, width of the bit and error counters.
REQ-002 Parameter SYNC_LEN, default 16, consecutive matching bits needed to declare lock.
REQ-003 Parameter LOSS_THRESH, default 8, errors within one 64-bit locked block that force loss of lock.
REQ-004 Parameter WINDOW_LEN, default 100000, locked bit count at which the ber_done pulse is issued.
REQ-005 Port clk, input, 1, single clock for all logic.
REQ-006 Port reset, input, 1, synchronous active-high reset.
REQ-007 Port data_in, input, 1, decoded bit from the viterbi stage (dec_out).
REQ-008 Port data_valid, input, 1, high when data_in carries a valid bit (dec_valid); a bit is sampled on every clk edge with data_valid high.
REQ-009 Port clear, input, 1, synchronous counter clear that does not affect lock state.
REQ-010 Port locked, output, 1, high while the checker is synchronised to the m-sequence.
REQ-011 Port bit_cnt, output, CNT_W, bits checked while locked.
REQ-012 Port err_cnt, output, CNT_W, bit errors detected while locked.
REQ-013 Port ber_done, output, 1, one-cycle pulse when bit_cnt reaches WINDOW_LEN.
REQ-014 Port first_err_idx, output, CNT_W, bit_cnt value at the first error since the last clear or reset.

Function
REQ-015 The reference sequence SHALL be the codebase m-sequence x^7+x^6+1 (period 127); expected bit = h[6] XOR h[5], where h is a 7-bit history shifted left with the new bit entering h[0].
REQ-016 FSM states: FILL, SYNC, LOCK.
- FILL: shift 7 valid bits into h, then go to SYNC.
REQ-017 SYNC:
- Compare each valid data_in with the expected bit; a match increments match_cnt.
- A mismatch zeroes match_cnt.
- h is always loaded with the received bit.
- Go to LOCK when match_cnt reaches SYNC_LEN.
REQ-018 LOCK:
- h is loaded with the expected (locally generated) bit, not the received bit, so that a single error is counted once.
- Each valid bit increments bit_cnt.
- Each mismatch increments err_cnt.
REQ-019 LOCK SHALL run a 6-bit block counter of valid bits and a per-block error counter.
- If the block error count reaches LOSS_THRESH, the FSM goes to FILL on the next edge, clearing h, match_cnt and the block counters.
- bit_cnt and err_cnt SHALL be retained.
REQ-020 bit_cnt and err_cnt SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-021 All outputs SHALL be registered; locked, the counters and ber_done reflect a bit sampled at edge N after edge N+1.
REQ-022 ber_done SHALL pulse exactly once, when bit_cnt transitions to WINDOW_LEN.
- It re-arms only on clear or reset.
REQ-023 Cycles with data_valid low SHALL leave all state unchanged.
REQ-024 If clear and a valid bit occur in the same cycle, clear wins: counters become 0 and that bit is not counted.
- Lock state still advances on that bit.

Reset
REQ-025 While reset is high on a clk edge, the following SHALL be set on that edge, overriding clear and data_valid:
- FSM to FILL
- h, match_cnt and block counters to 0
- locked=0, bit_cnt=0, err_cnt=0, ber_done=0, first_err_idx=0
REQ-026 Reset mid-LOCK SHALL discard lock; re-lock SHALL require 7+SYNC_LEN valid bits.

Configuration
REQ-027 Macro BER_FIRST_ERR_EN:
- Defined: first_err_idx captures bit_cnt on the first locked error after reset or clear and holds it.
- Undefined: first_err_idx is tied to 0 and no capture register is built.

Structure
REQ-028 Package vlc_pkg SHALL hold:
- m-sequence length (7) and tap constants
- FSM state enum typedef
- default CNT_W
REQ-029 Sub-module msq_predict (7-bit history register plus tap XOR, with load-select between received and predicted bit) is natural; all else stays in bit_ber_check.

Verification
REQ-030 Clean m-sequence, data_valid continuous, from reset: locked=1 after 7+16=23 valid bits; after 1000 further bits, bit_cnt=1000 and err_cnt=0.
REQ-031 Single bit inverted 50 bits after lock: err_cnt=1 (not 3), locked stays 1, first_err_idx=49 with BER_FIRST_ERR_EN.
REQ-032 8 inverted bits within one 64-bit block: locked=0 on the following cycle; err_cnt=8 retained; re-lock 23 valid bits later.
REQ-033 data_valid toggled 1/0 every cycle: lock after 23 valid bits (46 cycles); counts identical to the continuous case.
REQ-034 CNT_W=4, 20 errored-but-locked bits (LOSS_THRESH raised to 64): err_cnt saturates at 15.
REQ-035 reset asserted mid-LOCK, then clear with valid in the same cycle: outputs 0, locked=0; ber_done fires once at bit_cnt=WINDOW_LEN.
